// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central stall/flush controller for the 5-stage pipeline
// (F, D, A, C, W).
//
// Responsibilities:
//   * merge instruction/data cache stalls into a full front-end freeze
//   * sequence an iterative MDU op by holding the A stage for MDU_LAT cycles
//   * squash the wrong-path D instruction on a taken branch resolved in A
//   * insert bubbles for load-use hazards the A-stage bypass cannot cover
//
// Parameters:
//   MDU_LAT            total cycles an MDU op occupies A (2..255)
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   icache_stall       instruction cache miss pending
//   dcache_stall       data cache miss pending
//   fd_read_sel1/2     source registers of the instruction in D
//   fd_uses_rs1/2      D instruction really reads that source
//   da_is_load         instruction in A is a load
//   da_write_sel       destination register of the instruction in A
//   da_is_mdu          instruction in A is an MDU op
//   ac_is_load         instruction in C is a load
//   ac_write_sel       destination register of the instruction in C
//   a_branch_taken     branch/jump resolved taken in A
//   stall_f/d/a        hold the corresponding pipeline register
//   bubble_a           load a NOP into the D->A register
//   bubble_c           load a NOP into the A->C register
//   flush_fd           squash the F->D register
//   mdu_start          one-cycle start pulse to the MDU
//   mdu_busy           controller is in state BUSY
//   perf_stall_cycles  cycles with stall_d=1       (PIPE_CTRL_PERF_EN only)
//   perf_flushes       cycles with flush_fd=1      (PIPE_CTRL_PERF_EN only)
//
// Optional feature: define PIPE_CTRL_PERF_EN to add the two 32-bit wrapping
// performance counters and their output ports.

module pipe_ctrl #(
    parameter int MDU_LAT = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    input  logic [4:0]  fd_read_sel1,
    input  logic [4:0]  fd_read_sel2,
    input  logic        fd_uses_rs1,
    input  logic        fd_uses_rs2,
    input  logic        da_is_load,
    input  logic [4:0]  da_write_sel,
    input  logic        da_is_mdu,
    input  logic        ac_is_load,
    input  logic [4:0]  ac_write_sel,
    input  logic        a_branch_taken,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_a,
    output logic        bubble_a,
    output logic        bubble_c,
    output logic        flush_fd,
    output logic        mdu_start,
    output logic        mdu_busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
`endif
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // The start cycle and the release cycle are not counted by cnt, so the
    // counter only covers the MDU_LAT-2 hold cycles in between.
    localparam logic [7:0] CNT_INIT = 8'(MDU_LAT - 2);

    logic [0:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       init_q;

    logic cacheStall;
    logic rs1HitA, rs2HitA, rs1HitC, rs2HitC;
    logic loadUseHazard;

    assign cacheStall = icache_stall | dcache_stall;

    // A source only matters if it is really read and is not x0.
    assign rs1HitA = fd_uses_rs1 && (fd_read_sel1 != 5'd0) && (fd_read_sel1 == da_write_sel);
    assign rs2HitA = fd_uses_rs2 && (fd_read_sel2 != 5'd0) && (fd_read_sel2 == da_write_sel);
    assign rs1HitC = fd_uses_rs1 && (fd_read_sel1 != 5'd0) && (fd_read_sel1 == ac_write_sel);
    assign rs2HitC = fd_uses_rs2 && (fd_read_sel2 != 5'd0) && (fd_read_sel2 == ac_write_sel);

    assign loadUseHazard = (da_is_load && (rs1HitA || rs2HitA)) ||
                           (ac_is_load && (rs1HitC || rs2HitC));

    // init_q masks every output in the first cycle after reset, so nothing
    // the pipeline presents while it is still settling can start an op.
    assign mdu_busy = (state_q == BUSY) && !init_q;

    // Priority chain: cache stall, MDU sequencing, branch flush, load-use.
    // While BUSY the A stage holds the MDU op, so branches and load-use
    // checks are not evaluated; on the release cycle (cnt=0) da_is_mdu is
    // ignored so the finishing op is not restarted.
    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_a   = 1'b0;
        bubble_a  = 1'b0;
        bubble_c  = 1'b0;
        flush_fd  = 1'b0;
        mdu_start = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (!init_q) begin
            if (cacheStall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_a = 1'b1;
            end else if (state_q == BUSY) begin
                if (cnt_q != 8'd0) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    stall_a  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_d    = cnt_q - 8'd1;
                end else begin
                    state_d = RUN;
                end
            end else if (da_is_mdu) begin
                mdu_start = 1'b1;
                stall_f   = 1'b1;
                stall_d   = 1'b1;
                stall_a   = 1'b1;
                bubble_c  = 1'b1;
                state_d   = BUSY;
                cnt_d     = CNT_INIT;
            end else if (a_branch_taken) begin
                flush_fd = 1'b1;
                bubble_a = 1'b1;
            end else if (loadUseHazard) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                bubble_a = 1'b1;
            end
        end
    end

    // State, MDU counter and the post-reset output mask.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            init_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perfStall_q;
    logic [31:0] perfFlush_q;

    // Event counters; they wrap naturally at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perfStall_q <= 32'd0;
            perfFlush_q <= 32'd0;
        end else begin
            perfStall_q <= perfStall_q + {31'd0, stall_d};
            perfFlush_q <= perfFlush_q + {31'd0, flush_fd};
        end
    end

    assign perf_stall_cycles = perfStall_q;
    assign perf_flushes      = perfFlush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

   localparam int MDU_LAT = 4;

   logic clock = 1'b0;
   logic reset;
   logic icacheStall, dcacheStall;
   logic [4:0] fdReadSel1, fdReadSel2;
   logic fdUsesRs1, fdUsesRs2;
   logic daIsLoad, daIsMdu, acIsLoad, aBranchTaken;
   logic [4:0] daWriteSel, acWriteSel;
   logic stallF, stallD, stallA, bubbleA, bubbleC, flushFd, mduStart, mduBusy;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perfStallCycles, perfFlushes;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: whether an MDU op holds A, and how many cycles
   // of A occupancy it still needs (including the release cycle).
   bit mInit;
   bit mBusy;
   int mLeft;
   bit eStallF, eStallD, eStallA, eBubbleA, eBubbleC, eFlushFd, eMduStart, eMduBusy;
   logic [31:0] eStallCnt, eFlushCnt;

   pipe_ctrl #(.MDU_LAT(MDU_LAT)) dut (
      .clock(clock), .reset(reset),
      .icache_stall(icacheStall), .dcache_stall(dcacheStall),
      .fd_read_sel1(fdReadSel1), .fd_read_sel2(fdReadSel2),
      .fd_uses_rs1(fdUsesRs1), .fd_uses_rs2(fdUsesRs2),
      .da_is_load(daIsLoad), .da_write_sel(daWriteSel), .da_is_mdu(daIsMdu),
      .ac_is_load(acIsLoad), .ac_write_sel(acWriteSel),
      .a_branch_taken(aBranchTaken),
      .stall_f(stallF), .stall_d(stallD), .stall_a(stallA),
      .bubble_a(bubbleA), .bubble_c(bubbleC), .flush_fd(flushFd),
      .mdu_start(mduStart), .mdu_busy(mduBusy)
`ifdef PIPE_CTRL_PERF_EN
      , .perf_stall_cycles(perfStallCycles), .perf_flushes(perfFlushes)
`endif
   );

   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Does the instruction in D read a non-zero register that a load writes?
   function automatic bit readsLoadDest(input bit isLoad, input logic [4:0] dest);
      bit hit;
      hit = 1'b0;
      if (isLoad && dest != 5'd0) begin
         if (fdUsesRs1 && fdReadSel1 == dest) hit = 1'b1;
         if (fdUsesRs2 && fdReadSel2 == dest) hit = 1'b1;
      end
      return hit;
   endfunction

   // Expected outputs for the current inputs, derived from the priority rules.
   task automatic computeExpected();
      bit haz;
      {eStallF, eStallD, eStallA, eBubbleA, eBubbleC, eFlushFd, eMduStart} = '0;
      eMduBusy = mBusy && !mInit && !reset;
      haz = readsLoadDest(daIsLoad, daWriteSel) || readsLoadDest(acIsLoad, acWriteSel);
      if (reset || mInit) begin
         eMduBusy = 1'b0;
      end else if (icacheStall || dcacheStall) begin
         {eStallF, eStallD, eStallA} = 3'b111;
      end else if (mBusy) begin
         if (mLeft > 1) {eStallF, eStallD, eStallA, eBubbleC} = 4'b1111;
      end else if (daIsMdu) begin
         {eStallF, eStallD, eStallA, eBubbleC, eMduStart} = 5'b11111;
      end else if (aBranchTaken) begin
         {eFlushFd, eBubbleA} = 2'b11;
      end else if (haz) begin
         {eStallF, eStallD, eBubbleA} = 3'b111;
      end
   endtask

   task automatic checkAll();
      computeExpected();
      checkOutput("stall_f", stallF, eStallF);
      checkOutput("stall_d", stallD, eStallD);
      checkOutput("stall_a", stallA, eStallA);
      checkOutput("bubble_a", bubbleA, eBubbleA);
      checkOutput("bubble_c", bubbleC, eBubbleC);
      checkOutput("flush_fd", flushFd, eFlushFd);
      checkOutput("mdu_start", mduStart, eMduStart);
      checkOutput("mdu_busy", mduBusy, eMduBusy);
`ifdef PIPE_CTRL_PERF_EN
      checkOutput("perf_stall_cycles", perfStallCycles, eStallCnt);
      checkOutput("perf_flushes", perfFlushes, eFlushCnt);
`endif
   endtask

   // Advance the model across one rising edge, using the inputs and the
   // expected outputs of the cycle that just ended.
   task automatic advanceModel();
      if (reset) return;
      if (mInit) begin
         mInit = 1'b0;
         return;
      end
      eStallCnt += {31'd0, eStallD};
      eFlushCnt += {31'd0, eFlushFd};
      if (icacheStall || dcacheStall) return;
      if (mBusy) begin
         if (mLeft > 1) mLeft--;
         else mBusy = 1'b0;
      end else if (daIsMdu) begin
         mBusy = 1'b1;
         mLeft = MDU_LAT - 1;
      end
   endtask

   // Inputs are applied just after an edge; settle checks mid-cycle.
   task automatic settle();
      #2;
      checkAll();
   endtask

   task automatic step();
      @(posedge clock);
      advanceModel();
      #1;
   endtask

   task automatic clearInputs();
      {icacheStall, dcacheStall, fdUsesRs1, fdUsesRs2} = '0;
      {daIsLoad, daIsMdu, acIsLoad, aBranchTaken} = '0;
      {fdReadSel1, fdReadSel2, daWriteSel, acWriteSel} = '0;
   endtask

   task automatic applyStimulus();
      icacheStall  = ($urandom_range(0, 9) == 0);
      dcacheStall  = ($urandom_range(0, 9) == 0);
      fdReadSel1   = 5'($urandom_range(0, 3));
      fdReadSel2   = 5'($urandom_range(0, 3));
      fdUsesRs1    = 1'($urandom);
      fdUsesRs2    = 1'($urandom);
      daIsLoad     = 1'($urandom);
      daWriteSel   = 5'($urandom_range(0, 3));
      daIsMdu      = ($urandom_range(0, 6) == 0);
      acIsLoad     = 1'($urandom);
      acWriteSel   = 5'($urandom_range(0, 3));
      aBranchTaken = ($urandom_range(0, 4) == 0);
   endtask

   // Reset is raised away from any edge; its release leaves one masked cycle.
   task automatic doReset();
      reset = 1'b1;
      mInit = 1'b1;
      mBusy = 1'b0;
      mLeft = 0;
      eStallCnt = '0;
      eFlushCnt = '0;
      #1;
      checkAll();
      @(posedge clock);
      #3;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      clearInputs();
      #1;
      doReset();
      settle();
      step();

      // Load-use distance 1: two stalled cycles, then the consumer advances.
      daIsLoad = 1'b1; daWriteSel = 5'd5; fdUsesRs2 = 1'b1; fdReadSel2 = 5'd5;
      settle();
      checkOutput("lu_d1_stall_d", stallD, 1);
      checkOutput("lu_d1_bubble_a", bubbleA, 1);
      step();
      daIsLoad = 1'b0; acIsLoad = 1'b1; acWriteSel = 5'd5;
      settle();
      checkOutput("lu_d2_stall_d", stallD, 1);
      step();
      acIsLoad = 1'b0;
      settle();
      checkOutput("lu_done_stall_d", stallD, 0);
      step();

      // Load of x0 consumed by D: never a hazard.
      daIsLoad = 1'b1; daWriteSel = 5'd0; fdUsesRs1 = 1'b1; fdReadSel1 = 5'd0;
      fdReadSel2 = 5'd0;
      settle();
      checkOutput("lu_x0_stall_d", stallD, 0);
      step();
      clearInputs();

      // MDU op with MDU_LAT=4: start in cycle 0, release in cycle 3.
      daIsMdu = 1'b1;
      settle();
      checkOutput("mdu_c0_start", mduStart, 1);
      checkOutput("mdu_c0_stall_a", stallA, 1);
      step();
      for (int c = 1; c < MDU_LAT; c++) begin
         settle();
         checkOutput("mdu_busy_cycle", mduBusy, 1);
         checkOutput("mdu_stall_a_cycle", stallA, (c < MDU_LAT - 1) ? 1 : 0);
         checkOutput("mdu_no_restart", mduStart, 0);
         step();
      end
      daIsMdu = 1'b0;
      settle();
      checkOutput("mdu_after_busy", mduBusy, 0);
      step();

      // Branch together with a load-use hazard: flush wins, no stall.
      aBranchTaken = 1'b1; daIsLoad = 1'b1; daWriteSel = 5'd7;
      fdUsesRs1 = 1'b1; fdReadSel1 = 5'd7;
      settle();
      checkOutput("br_flush_fd", flushFd, 1);
      checkOutput("br_bubble_a", bubbleA, 1);
      checkOutput("br_stall_d", stallD, 0);
      step();
      clearInputs();

      // dcache stall for 3 cycles while BUSY with two hold cycles pending.
      daIsMdu = 1'b1;
      settle();
      step();
      dcacheStall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         checkOutput("dc_busy_stall_a", stallA, 1);
         checkOutput("dc_busy_bubble_c", bubbleC, 0);
         step();
      end
      dcacheStall = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         checkOutput("dc_release_stall_a", stallA, (c < 2) ? 1 : 0);
         step();
      end
      daIsMdu = 1'b0;
      settle();
      step();

      // Reset pulse in the middle of BUSY; restart two cycles later.
      daIsMdu = 1'b1;
      settle();
      step();
      settle();
      checkOutput("rst_pre_busy", mduBusy, 1);
      doReset();
      checkOutput("rst_busy_dropped", mduBusy, 0);
      settle();
      checkOutput("rst_masked_start", mduStart, 0);
      step();
      settle();
      checkOutput("rst_fresh_start", mduStart, 1);
      step();
      daIsMdu = 1'b0;
      for (int c = 1; c < MDU_LAT; c++) begin
         settle();
         step();
      end

      // Cache stall in the start cycle suppresses the start; retried after.
      daIsMdu = 1'b1; icacheStall = 1'b1;
      settle();
      checkOutput("cs_start_suppressed", mduStart, 0);
      step();
      icacheStall = 1'b0;
      settle();
      checkOutput("cs_start_retried", mduStart, 1);
      step();
      daIsMdu = 1'b0;
      for (int c = 1; c < MDU_LAT; c++) begin
         settle();
         step();
      end

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 800; n++) begin
         applyStimulus();
         if ($urandom_range(0, 99) == 0) doReset();
         settle();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
